// File: rtl/alu_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : alu_sequencer
// Purpose  : Four-state instruction sequencer around an external ALU. It owns
//            an 8 x 16-bit register file and a 4-bit {S,Z,C,V} flag register.
//            Each instruction runs IDLE -> READ -> EXEC -> WB -> IDLE, so
//            timing is the same for every opcode.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   RESET_FLAGS      flag register value after reset
// Ports
//   clk              rising-edge clock
//   rst_n            asynchronous active-low reset
//   in_valid/ready   instruction handshake (ready only in IDLE with ld_en=0)
//   in_op/rd/rs      opcode, destination (= operand A) and operand-B register
//   ld_en/addr/data  external register load, honoured only in IDLE
//   alu_a/b/op       registered ALU operands, non-zero only during EXEC
//   alu_res/szcv     combinational ALU result and condition code
//   flags            architectural {S,Z,C,V}
//   done/err         one-cycle retirement pulses (err for illegal opcodes)
//   dbg_addr/data    combinational register file read port
// ============================================================================
module alu_sequencer #(
  parameter logic [3:0] RESET_FLAGS = 4'b0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  in_op,
  input  logic [2:0]  in_rd,
  input  logic [2:0]  in_rs,
  input  logic        ld_en,
  input  logic [2:0]  ld_addr,
  input  logic [15:0] ld_data,
  output logic [15:0] alu_a,
  output logic [15:0] alu_b,
  output logic [3:0]  alu_op,
  input  logic [15:0] alu_res,
  input  logic [3:0]  alu_szcv,
  output logic [3:0]  flags,
  output logic        done,
  output logic        err,
  input  logic [2:0]  dbg_addr,
  output logic [15:0] dbg_data
);

  // --------------------------------------------------------------------------
  // Opcode map
  // --------------------------------------------------------------------------
  localparam logic [3:0] c_op_add = 4'd0;
  localparam logic [3:0] c_op_sub = 4'd1;
  localparam logic [3:0] c_op_and = 4'd2;
  localparam logic [3:0] c_op_or  = 4'd3;
  localparam logic [3:0] c_op_xor = 4'd4;
  localparam logic [3:0] c_op_cmp = 4'd5;
  localparam logic [3:0] c_op_mov = 4'd6;
  localparam logic [3:0] c_op_sll = 4'd8;
  localparam logic [3:0] c_op_slr = 4'd9;
  localparam logic [3:0] c_op_srl = 4'd10;
  localparam logic [3:0] c_op_sra = 4'd11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    EXEC = 2'd2,
    WB   = 2'd3
  } state_t;

  // Opcodes that write the result back to rd and update flags.
  function automatic logic op_writes(input logic [3:0] op);
    case (op)
      c_op_add, c_op_sub, c_op_and, c_op_or, c_op_xor,
      c_op_mov, c_op_sll, c_op_slr, c_op_srl, c_op_sra: op_writes = 1'b1;
      default:                                          op_writes = 1'b0;
    endcase
  endfunction

  // Everything that neither writes back nor is CMP: 7 and 12..15.
  function automatic logic op_illegal(input logic [3:0] op);
    op_illegal = !op_writes(op) && (op != c_op_cmp);
  endfunction

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  state_t             state_q,  state_d;
  logic [3:0]         op_q,     op_d;
  logic [2:0]         rd_q,     rd_d;
  logic [2:0]         rs_q,     rs_d;
  // The ALU operand flops double as the A/B operand registers: they are
  // loaded from the register file on the READ->EXEC edge and cleared on
  // leaving EXEC, so the outputs read zero in every other state.
  logic [15:0]        alu_a_q,  alu_a_d;
  logic [15:0]        alu_b_q,  alu_b_d;
  logic [3:0]         alu_op_q, alu_op_d;
  logic [15:0]        res_q,    res_d;
  logic [3:0]         szcv_q,   szcv_d;
  logic [3:0]         flags_q,  flags_d;
  logic               done_q,   done_d;
  logic               err_q,    err_d;
  logic [7:0][15:0]   rf_q,     rf_d;

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    rd_d     = rd_q;
    rs_d     = rs_q;
    res_d    = res_q;
    szcv_d   = szcv_q;
    flags_d  = flags_q;
    rf_d     = rf_q;
    alu_a_d  = 16'h0000;
    alu_b_d  = 16'h0000;
    alu_op_d = 4'h0;
    done_d   = 1'b0;
    err_d    = 1'b0;

    case (state_q)
      IDLE: begin
        // A load always wins over an offered instruction.
        if (ld_en) begin
          rf_d[ld_addr] = ld_data;
        end else if (in_valid) begin
          op_d    = in_op;
          rd_d    = in_rd;
          rs_d    = in_rs;
          state_d = READ;
        end
      end

      READ: begin
        // Both operands sample the same pre-instruction register file,
        // so rd==rs yields identical A and B values.
        alu_a_d  = rf_q[rd_q];
        alu_b_d  = rf_q[rs_q];
        alu_op_d = op_q;
        state_d  = EXEC;
      end

      EXEC: begin
        res_d   = alu_res;
        szcv_d  = alu_szcv;
        // done/err are registered, so they are raised on the EXEC->WB edge
        // and are visible for exactly the WB cycle.
        done_d  = 1'b1;
        err_d   = op_illegal(op_q);
        state_d = WB;
      end

      WB: begin
        if (op_writes(op_q)) begin
          rf_d[rd_q] = res_q;
        end
        if (op_writes(op_q) || (op_q == c_op_cmp)) begin
          flags_d = szcv_q;
        end
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      op_q     <= 4'h0;
      rd_q     <= 3'h0;
      rs_q     <= 3'h0;
      alu_a_q  <= 16'h0000;
      alu_b_q  <= 16'h0000;
      alu_op_q <= 4'h0;
      res_q    <= 16'h0000;
      szcv_q   <= 4'h0;
      flags_q  <= RESET_FLAGS;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      rf_q     <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      rd_q     <= rd_d;
      rs_q     <= rs_d;
      alu_a_q  <= alu_a_d;
      alu_b_q  <= alu_b_d;
      alu_op_q <= alu_op_d;
      res_q    <= res_d;
      szcv_q   <= szcv_d;
      flags_q  <= flags_d;
      done_q   <= done_d;
      err_q    <= err_d;
      rf_q     <= rf_d;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign in_ready = (state_q == IDLE) && !ld_en;
  assign alu_a    = alu_a_q;
  assign alu_b    = alu_b_q;
  assign alu_op   = alu_op_q;
  assign flags    = flags_q;
  assign done     = done_q;
  assign err      = err_q;
  assign dbg_data = rf_q[dbg_addr];

endmodule
`default_nettype wire

// File: tb/tb_alu_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_sequencer
// Purpose  : Self-checking bench for alu_sequencer. Provides a behavioural
//            ALU, drives a vector table plus hand-written corner sequences,
//            and checks retirements against a scoreboard queue.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_sequencer;

  localparam logic [3:0] c_reset_flags = 4'b0110;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_op;
  logic [2:0]  in_rd;
  logic [2:0]  in_rs;
  logic        ld_en;
  logic [2:0]  ld_addr;
  logic [15:0] ld_data;
  logic [15:0] alu_a;
  logic [15:0] alu_b;
  logic [3:0]  alu_op;
  logic [15:0] alu_res;
  logic [3:0]  alu_szcv;
  logic [3:0]  flags;
  logic        done;
  logic        err;
  logic [2:0]  dbg_addr;
  logic [15:0] dbg_data;

  alu_sequencer #(.RESET_FLAGS(c_reset_flags)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_op    (in_op),
    .in_rd    (in_rd),
    .in_rs    (in_rs),
    .ld_en    (ld_en),
    .ld_addr  (ld_addr),
    .ld_data  (ld_data),
    .alu_a    (alu_a),
    .alu_b    (alu_b),
    .alu_op   (alu_op),
    .alu_res  (alu_res),
    .alu_szcv (alu_szcv),
    .flags    (flags),
    .done     (done),
    .err      (err),
    .dbg_addr (dbg_addr),
    .dbg_data (dbg_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // --------------------------------------------------------------------------
  // Behavioural ALU: returns {S,Z,C,V, result}
  // --------------------------------------------------------------------------
  function automatic logic [19:0] alu_model(input logic [15:0] a, input logic [15:0] b,
                                            input logic [3:0] op);
    logic [16:0] wide;
    logic [31:0] rot;
    logic [15:0] r;
    logic        c;
    logic        v;
    int          sh;
    sh = int'(b[3:0]);
    c  = 1'b0;
    v  = 1'b0;
    r  = 16'h0000;
    case (op)
      4'd0: begin
        wide = {1'b0, a} + {1'b0, b};
        r = wide[15:0]; c = wide[16];
        v = (a[15] == b[15]) && (r[15] != a[15]);
      end
      4'd1, 4'd5: begin
        r = a - b; c = (a < b);
        v = (a[15] != b[15]) && (r[15] != a[15]);
      end
      4'd2: r = a & b;
      4'd3: r = a | b;
      4'd4: r = a ^ b;
      4'd6: r = b;
      4'd8: begin
        r = a << sh;
        c = (sh == 0) ? 1'b0 : a[16 - sh];
      end
      4'd9: begin
        rot = {16'h0000, a} << sh;
        r = rot[15:0] | rot[31:16];
      end
      4'd10: begin
        r = a >> sh;
        c = (sh == 0) ? 1'b0 : a[sh - 1];
      end
      4'd11: begin
        r = $signed(a) >>> sh;
        c = (sh == 0) ? 1'b0 : a[sh - 1];
      end
      // Illegal opcodes: distinctive garbage so a stray write is visible.
      default: return {4'b1111, 16'hDEAD};
    endcase
    return {r[15], (r == 16'h0000), c, v, r};
  endfunction

  assign {alu_szcv, alu_res} = alu_model(alu_a, alu_b, alu_op);

  // --------------------------------------------------------------------------
  // Checking infrastructure
  // --------------------------------------------------------------------------
  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [2:0]  rd;
    logic [15:0] val;
    logic [3:0]  flags;
    logic        err;
    int          done_cyc;
  } exp_t;

  exp_t sb_q[$];
  exp_t cur;
  logic post_pending = 1'b0;

  // Monitor: on a done pulse, pop the scoreboard and check the pulse; one
  // cycle later check the architectural effect of the retirement.
  always @(negedge clk) begin
    if (!rst_n) begin
      post_pending = 1'b0;
    end else begin
      if (post_pending) begin
        check("flags_after_wb", 32'(flags), 32'(cur.flags));
        check("rd_after_wb", 32'(dbg_data), 32'(cur.val));
        check("done_one_cycle", 32'(done), 32'd0);
        check("ready_after_wb", 32'(in_ready), 32'd1);
        post_pending = 1'b0;
      end
      if (done) begin
        if (sb_q.size() == 0) begin
          check("unexpected_done", 32'(done), 32'd0);
        end else begin
          cur = sb_q.pop_front();
          check("err_at_done", 32'(err), 32'(cur.err));
          check("done_latency", 32'(cyc), 32'(cur.done_cyc));
          check("busy_not_ready", 32'(in_ready), 32'd0);
          post_pending = 1'b1;
        end
      end else begin
        check("err_without_done", 32'(err), 32'd0);
      end
    end
  end

  // --------------------------------------------------------------------------
  // Driver helpers
  // --------------------------------------------------------------------------
  task automatic load_reg(input logic [2:0] addr, input logic [15:0] data);
    @(negedge clk);
    ld_en = 1'b1; ld_addr = addr; ld_data = data;
    @(negedge clk);
    ld_en = 1'b0;
  endtask

  task automatic wait_retired();
    int n;
    n = 0;
    while ((sb_q.size() != 0 || post_pending) && n < 20) begin
      @(negedge clk);
      #2;
      n++;
    end
    if (sb_q.size() != 0 || post_pending) check("retire_timeout", 32'd1, 32'd0);
  endtask

  task automatic issue(input logic [3:0] op, input logic [2:0] rd, input logic [2:0] rs,
                       input logic [15:0] exp_val, input logic [3:0] exp_flags,
                       input logic exp_err);
    exp_t e;
    @(negedge clk);
    #1;
    check("ready_before_issue", 32'(in_ready), 32'd1);
    in_valid = 1'b1; in_op = op; in_rd = rd; in_rs = rs; dbg_addr = rd;
    e.rd = rd; e.val = exp_val; e.flags = exp_flags; e.err = exp_err;
    e.done_cyc = cyc + 3;
    sb_q.push_back(e);
    @(negedge clk);
    // Garbage after accept must be ignored.
    in_valid = 1'b1; in_op = ~op; in_rd = ~rd; in_rs = ~rs;
    @(negedge clk);
    in_valid = 1'b0;
    wait_retired();
  endtask

  typedef struct {
    logic [3:0]  op;
    logic [2:0]  rd;
    logic [2:0]  rs;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] exp_val;
    logic [3:0]  exp_flags;
    logic        exp_err;
  } vec_t;

  vec_t vecs[16];

  // --------------------------------------------------------------------------
  // Test sequence
  // --------------------------------------------------------------------------
  initial begin
    exp_t e;

    // op rd rs a b -> result flags err (flags of illegal ops = preceding row)
    vecs[0]  = '{4'd0,  3'd1, 3'd2, 16'h7FFF, 16'h0001, 16'h8000, 4'b1001, 1'b0};
    vecs[1]  = '{4'd7,  3'd4, 3'd5, 16'h1111, 16'h2222, 16'h1111, 4'b1001, 1'b1};
    vecs[2]  = '{4'd5,  3'd3, 3'd4, 16'h0005, 16'h0005, 16'h0005, 4'b0100, 1'b0};
    vecs[3]  = '{4'd8,  3'd5, 3'd6, 16'h8001, 16'h0001, 16'h0002, 4'b0010, 1'b0};
    vecs[4]  = '{4'd1,  3'd0, 3'd7, 16'h0003, 16'h0005, 16'hFFFE, 4'b1010, 1'b0};
    vecs[5]  = '{4'd2,  3'd2, 3'd3, 16'hF0F0, 16'h0FF0, 16'h00F0, 4'b0000, 1'b0};
    vecs[6]  = '{4'd3,  3'd4, 3'd5, 16'h0000, 16'h0000, 16'h0000, 4'b0100, 1'b0};
    vecs[7]  = '{4'd4,  3'd6, 3'd7, 16'hAAAA, 16'h5555, 16'hFFFF, 4'b1000, 1'b0};
    vecs[8]  = '{4'd6,  3'd1, 3'd2, 16'h1234, 16'h8000, 16'h8000, 4'b1000, 1'b0};
    vecs[9]  = '{4'd10, 3'd3, 3'd4, 16'h8003, 16'h0002, 16'h2000, 4'b0010, 1'b0};
    vecs[10] = '{4'd11, 3'd5, 3'd6, 16'h8004, 16'h0002, 16'hE001, 4'b1000, 1'b0};
    vecs[11] = '{4'd9,  3'd7, 3'd0, 16'h8001, 16'h0004, 16'h0018, 4'b0000, 1'b0};
    vecs[12] = '{4'd0,  3'd0, 3'd1, 16'hFFFF, 16'h0001, 16'h0000, 4'b0110, 1'b0};
    vecs[13] = '{4'd0,  3'd2, 3'd2, 16'h4000, 16'h4000, 16'h8000, 4'b1001, 1'b0};
    vecs[14] = '{4'd12, 3'd4, 3'd5, 16'h1111, 16'h2222, 16'h1111, 4'b1001, 1'b1};
    vecs[15] = '{4'd15, 3'd6, 3'd7, 16'h3333, 16'h4444, 16'h3333, 4'b1001, 1'b1};

    rst_n = 1'b0; in_valid = 1'b0; in_op = 4'h0; in_rd = 3'h0; in_rs = 3'h0;
    ld_en = 1'b0; ld_addr = 3'h0; ld_data = 16'h0000; dbg_addr = 3'h0;
    repeat (2) @(negedge clk);

    // Reset state
    check("rst_flags", 32'(flags), 32'(c_reset_flags));
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_alu_a", 32'(alu_a), 32'd0);
    check("rst_alu_op", 32'(alu_op), 32'd0);
    rst_n = 1'b1;
    #1;
    check("ready_after_rst", 32'(in_ready), 32'd1);
    for (int i = 0; i < 8; i++) begin
      dbg_addr = 3'(i);
      #1;
      check("rst_reg", 32'(dbg_data), 32'd0);
    end

    // Table-driven instructions
    for (int i = 0; i < 16; i++) begin
      load_reg(vecs[i].rd, vecs[i].a);
      if (vecs[i].rs != vecs[i].rd) load_reg(vecs[i].rs, vecs[i].b);
      issue(vecs[i].op, vecs[i].rd, vecs[i].rs,
            vecs[i].exp_val, vecs[i].exp_flags, vecs[i].exp_err);
    end

    // Illegal opcodes left neighbouring registers alone
    dbg_addr = 3'd7;
    #1;
    check("illegal_keeps_r7", 32'(dbg_data), 32'h4444);

    // Load and instruction offered together: load wins, accept next cycle
    @(negedge clk);
    ld_en = 1'b1; ld_addr = 3'd3; ld_data = 16'hBEEF;
    in_valid = 1'b1; in_op = 4'd0; in_rd = 3'd3; in_rs = 3'd3; dbg_addr = 3'd3;
    #1;
    check("ld_blocks_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    ld_en = 1'b0;
    #1;
    check("ld_data_visible", 32'(dbg_data), 32'hBEEF);
    check("ready_after_ld", 32'(in_ready), 32'd1);
    e.rd = 3'd3; e.val = 16'h7DDE; e.flags = 4'b0011; e.err = 1'b0;
    e.done_cyc = cyc + 3;
    sb_q.push_back(e);
    @(negedge clk);
    in_valid = 1'b0;
    // ld_en while busy must be ignored
    ld_en = 1'b1; ld_addr = 3'd0; ld_data = 16'hFACE;
    @(negedge clk);
    ld_en = 1'b0;
    wait_retired();
    dbg_addr = 3'd0;
    #1;
    check("busy_ld_ignored", 32'(dbg_data), 32'h0000);

    // Reset asserted during EXEC aborts the instruction
    load_reg(3'd1, 16'h0001);
    load_reg(3'd2, 16'h0002);
    @(negedge clk);
    in_valid = 1'b1; in_op = 4'd4; in_rd = 3'd1; in_rs = 3'd2;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    check("exec_alu_op", 32'(alu_op), 32'd4);
    check("exec_alu_a", 32'(alu_a), 32'h0001);
    check("exec_alu_b", 32'(alu_b), 32'h0002);
    rst_n = 1'b0;
    #1;
    check("async_rst_alu_a", 32'(alu_a), 32'd0);
    check("async_rst_flags", 32'(flags), 32'(c_reset_flags));
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("ready_after_abort", 32'(in_ready), 32'd1);
    repeat (4) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      dbg_addr = 3'(i);
      #1;
      check("abort_reg_clear", 32'(dbg_data), 32'd0);
    end
    check("abort_flags", 32'(flags), 32'(c_reset_flags));
    check("abort_sb_empty", 32'(sb_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
